// File: rtl/vga_output_stage.sv
// Final pixel stage: aligns sync/active/counters to the renderer RGB latency, blanks, registers DAC outputs
// and tracks per-frame status. Optional border overlay is enabled by defining VGA_BORDER_EN.
module vga_output_stage #(
  parameter int unsigned SYNC_DELAY = 2,
  parameter int unsigned H_LAST     = 639,
  parameter int unsigned V_LAST     = 479
) (
  input  logic        video_clk,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        display_active,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [11:0] rgb_in,
  input  logic        pixel_valid,
  input  logic [11:0] border_color,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [7:0]  frame_count,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned CW   = 10;
  localparam int unsigned RGBW = 12;
  localparam int unsigned FCW  = 8;

  logic [SYNC_DELAY-1:0] hs_pipe;
  logic [SYNC_DELAY-1:0] vs_pipe;
  logic [SYNC_DELAY-1:0] act_pipe;
  logic [CW-1:0]         hc_pipe [SYNC_DELAY];
  logic [CW-1:0]         vc_pipe [SYNC_DELAY];

  logic            d_hsync;
  logic            d_vsync;
  logic            d_active;
  logic [CW-1:0]   d_hcount;
  logic [CW-1:0]   d_vcount;
  logic            border_px;
  logic            vs_prev;
  logic            vs_fall;
  logic            ur_set;
  logic [RGBW-1:0] rgb_next;

  // Sync/active/counter delay line; flushes to inactive values on reset
  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      act_pipe <= '0;
      for (int i = 0; i < int'(SYNC_DELAY); i++) begin
        hc_pipe[i] <= '0;
        vc_pipe[i] <= '0;
      end
    end else begin
      hs_pipe[0]  <= hsync_in;
      vs_pipe[0]  <= vsync_in;
      act_pipe[0] <= display_active;
      hc_pipe[0]  <= hcount;
      vc_pipe[0]  <= vcount;
      for (int i = 1; i < int'(SYNC_DELAY); i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
        hc_pipe[i]  <= hc_pipe[i-1];
        vc_pipe[i]  <= vc_pipe[i-1];
      end
    end
  end

  assign d_hsync  = hs_pipe[SYNC_DELAY-1];
  assign d_vsync  = vs_pipe[SYNC_DELAY-1];
  assign d_active = act_pipe[SYNC_DELAY-1];
  assign d_hcount = hc_pipe[SYNC_DELAY-1];
  assign d_vcount = vc_pipe[SYNC_DELAY-1];

`ifdef VGA_BORDER_EN
  assign border_px = d_active && ((d_hcount == CW'(0)) || (d_hcount == CW'(H_LAST)) ||
                                  (d_vcount == CW'(0)) || (d_vcount == CW'(V_LAST)));
`else
  logic unused_coords;
  assign border_px     = 1'b0;
  assign unused_coords = ^{d_hcount, d_vcount};
`endif

  assign vs_fall = vs_prev & ~d_vsync;
  assign ur_set  = d_active & ~pixel_valid & ~border_px;

  // Colour select: blanking outside active video is absolute
  always_comb begin
    rgb_next = '0;
    if (border_px) begin
      rgb_next = border_color;
    end else if (d_active && pixel_valid) begin
      rgb_next = rgb_in;
    end
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync              <= 1'b1;
      vsync              <= 1'b1;
      {red, green, blue} <= '0;
      vs_prev            <= 1'b1;
      frame_start        <= 1'b0;
      frame_count        <= '0;
      underrun           <= 1'b0;
    end else begin
      hsync              <= d_hsync;
      vsync              <= d_vsync;
      {red, green, blue} <= rgb_next;
      vs_prev            <= d_vsync;
      frame_start        <= vs_fall;
      if (vs_fall) begin
        frame_count <= frame_count + FCW'(1);
      end
      // Frame boundary clear takes priority over a same-cycle underrun
      if (vs_fall) begin
        underrun <= 1'b0;
      end else if (ur_set) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_output_stage.sv
// Directed bench for vga_output_stage: hand-computed vector table, clear-priority, mid-line reset
// and a small-geometry multi-frame sweep with frame counter wrap.
module tb_vga_output_stage;

  localparam int unsigned SD = 2;
  localparam int unsigned HL = 5;
  localparam int unsigned VL = 3;

  logic        video_clk;
  logic        reset_n;
  logic        hsync_in, vsync_in, display_active, pixel_valid;
  logic [9:0]  hcount, vcount;
  logic [11:0] rgb_in, border_color;
  logic        hsync, vsync, frame_start, underrun;
  logic [3:0]  red, green, blue;
  logic [7:0]  frame_count;

  vga_output_stage #(.SYNC_DELAY(SD), .H_LAST(HL), .V_LAST(VL)) dut (
    .video_clk(video_clk), .reset_n(reset_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_active(display_active),
    .hcount(hcount), .vcount(vcount), .rgb_in(rgb_in), .pixel_valid(pixel_valid),
    .border_color(border_color),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_count(frame_count), .frame_start(frame_start), .underrun(underrun)
  );

  initial video_clk = 1'b0;
  always #20 video_clk = ~video_clk;

  typedef struct packed {
    logic       hs, vs, act, pv;
    logic [11:0] rgb;
    logic       e_hs, e_vs;
    logic [11:0] e_rgb;
    logic       e_fs, e_ur;
    logic [7:0] e_fc;
  } vec_t;

  typedef struct packed {
    logic       hs, vs, act;
    logic [9:0] hc, vc;
  } raw_t;

  int n_chk = 0;
  int n_pass = 0;
  int fs_cnt = 0;
  int nz_cnt = 0;
  int fs_save;

  raw_t       past [SD+1];
  logic [7:0] m_fc;
  logic       m_ur;
  vec_t       tbl [15];

  function automatic vec_t vec(input logic [3:0] ins, input logic [11:0] rgb, input logic [1:0] eo,
                               input logic [11:0] ergb, input logic [1:0] fsur, input logic [7:0] fc);
    vec_t v;
    {v.hs, v.vs, v.act, v.pv} = ins;
    v.rgb = rgb;
    {v.e_hs, v.e_vs} = eo;
    v.e_rgb = ergb;
    {v.e_fs, v.e_ur} = fsur;
    v.e_fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [23:0] exp);
    logic [23:0] got;
    got = {hsync, vsync, red, green, blue, frame_start, underrun, frame_count};
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got hs=%b vs=%b rgb=%h fs=%b ur=%b fc=%0d, required hs=%b vs=%b rgb=%h fs=%b ur=%b fc=%0d",
                  name, $time, got[23], got[22], got[21:10], got[9], got[8], got[7:0],
                  exp[23], exp[22], exp[21:10], exp[9], exp[8], exp[7:0]);
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, required %0d", name, $time, got, exp);
  endtask

  task automatic model_idle(input logic [9:0] hc, input logic [9:0] vc, input logic [7:0] fc);
    for (int i = 0; i <= int'(SD); i++) past[i] = '{1'b1, 1'b1, 1'b0, hc, vc};
    m_fc = fc;
    m_ur = 1'b0;
  endtask

  // One pixel clock: predict from the raw-input history, drive, step, compare
  task automatic cyc(input logic hs, input logic vs, input logic act, input logic [9:0] hc,
                     input logic [9:0] vc, input logic [11:0] rgb, input logic pv, input string name);
    raw_t        d;
    logic        fall, brd;
    logic [11:0] e_rgb;
    d    = past[SD-1];
    fall = past[SD].vs & ~d.vs;
`ifdef VGA_BORDER_EN
    brd = d.act && (d.hc == 10'd0 || d.hc == 10'(HL) || d.vc == 10'd0 || d.vc == 10'(VL));
`else
    brd = 1'b0;
`endif
    e_rgb = brd ? border_color : ((d.act && pv) ? rgb : 12'h000);
    if (fall) begin
      m_fc = m_fc + 8'd1;
      m_ur = 1'b0;
    end else if (d.act && !pv && !brd) begin
      m_ur = 1'b1;
    end
    hsync_in = hs; vsync_in = vs; display_active = act;
    hcount = hc; vcount = vc; rgb_in = rgb; pixel_valid = pv;
    @(posedge video_clk); #1;
    check(name, {d.hs, d.vs, e_rgb, fall, m_ur, m_fc});
    for (int i = int'(SD); i > 0; i--) past[i] = past[i-1];
    past[0] = '{hs, vs, act, hc, vc};
    if (frame_start) fs_cnt++;
    if ({red, green, blue} != 12'h000) nz_cnt++;
  endtask

  // Small frame: 10 columns (6 active), 6 lines (4 active), vsync low on line 5
  task automatic frame(input int bad_h, input int bad_v, input logic [11:0] col);
    logic pv;
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < 10; h++) begin
        pv = !(past[SD-1].act && past[SD-1].hc == 10'(bad_h) && past[SD-1].vc == 10'(bad_v));
        if (v == 4 && h == 0 && bad_h >= 0) check_val("underrun_sticky", int'(underrun), 1);
        cyc((h >= 7 && h <= 8) ? 1'b0 : 1'b1, (v != 5), (h < 6 && v < 4), 10'(h), 10'(v), col, pv, "sweep");
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; display_active = 1'b0; pixel_valid = 1'b1;
    hcount = 10'd3; vcount = 10'd2; rgb_in = 12'h000; border_color = 12'h00F;

    //            {hs,vs,act,pv} rgb_in   {hs,vs} rgb_out  {fs,ur} fc
    tbl[0]  = vec(4'b1111, 12'h123, 2'b11, 12'h000, 2'b00, 8'd0);
    tbl[1]  = vec(4'b1111, 12'h456, 2'b11, 12'h000, 2'b00, 8'd0);
    tbl[2]  = vec(4'b0101, 12'hF0A, 2'b11, 12'hF0A, 2'b00, 8'd0);
    tbl[3]  = vec(4'b0100, 12'h0FF, 2'b11, 12'h000, 2'b01, 8'd0);
    tbl[4]  = vec(4'b1001, 12'hABC, 2'b01, 12'h000, 2'b01, 8'd0);
    tbl[5]  = vec(4'b1001, 12'h111, 2'b01, 12'h000, 2'b01, 8'd0);
    tbl[6]  = vec(4'b1011, 12'h222, 2'b10, 12'h000, 2'b10, 8'd1);
    tbl[7]  = vec(4'b1111, 12'h333, 2'b10, 12'h000, 2'b00, 8'd1);
    tbl[8]  = vec(4'b1101, 12'h7E5, 2'b10, 12'h7E5, 2'b00, 8'd1);
    tbl[9]  = vec(4'b1000, 12'h999, 2'b11, 12'h000, 2'b01, 8'd1);
    tbl[10] = vec(4'b1001, 12'h000, 2'b11, 12'h000, 2'b01, 8'd1);
    tbl[11] = vec(4'b1101, 12'h000, 2'b10, 12'h000, 2'b10, 8'd2);
    tbl[12] = vec(4'b1101, 12'h000, 2'b10, 12'h000, 2'b00, 8'd2);
    tbl[13] = vec(4'b1101, 12'h000, 2'b11, 12'h000, 2'b00, 8'd2);
    tbl[14] = vec(4'b1101, 12'h000, 2'b11, 12'h000, 2'b00, 8'd2);

    #25;
    check("reset_values", {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 8'd0});
    @(negedge video_clk); reset_n = 1'b1;
    @(posedge video_clk); #1;

    for (int k = 0; k < 15; k++) begin
      hsync_in = tbl[k].hs; vsync_in = tbl[k].vs; display_active = tbl[k].act;
      pixel_valid = tbl[k].pv; rgb_in = tbl[k].rgb;
      @(posedge video_clk); #1;
      check($sformatf("tbl[%0d]", k), {tbl[k].e_hs, tbl[k].e_vs, tbl[k].e_rgb, tbl[k].e_fs, tbl[k].e_ur, tbl[k].e_fc});
    end

    // Vsync fall coincident with an active invalid pixel: clear must win
    model_idle(10'd3, 10'd2, 8'd2);
    cyc(1'b1, 1'b1, 1'b1, 10'd3, 10'd2, 12'h000, 1'b1, "cw_a");
    cyc(1'b1, 1'b0, 1'b1, 10'd4, 10'd2, 12'h000, 1'b1, "cw_b");
    cyc(1'b1, 1'b0, 1'b0, 10'd3, 10'd2, 12'h333, 1'b1, "cw_c");
    cyc(1'b1, 1'b0, 1'b0, 10'd3, 10'd2, 12'h444, 1'b0, "cw_d");
    check_val("clear_wins", int'(underrun), 0);
    cyc(1'b1, 1'b1, 1'b0, 10'd3, 10'd2, 12'h000, 1'b1, "cw_e");
    cyc(1'b1, 1'b1, 1'b0, 10'd3, 10'd2, 12'h000, 1'b1, "cw_f");

    // Mid-line reset with underrun set and a non-zero frame count
    cyc(1'b1, 1'b1, 1'b1, 10'd318, 10'd2, 12'h5A5, 1'b1, "pre_rst");
    cyc(1'b1, 1'b1, 1'b1, 10'd319, 10'd2, 12'h5A5, 1'b1, "pre_rst");
    cyc(1'b0, 1'b1, 1'b1, 10'd320, 10'd2, 12'h5A5, 1'b0, "pre_rst");
    cyc(1'b0, 1'b1, 1'b1, 10'd320, 10'd2, 12'h5A5, 1'b1, "pre_rst");
    reset_n = 1'b0;
    #1;
    check("async_reset", {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 8'd0});
    repeat (3) @(posedge video_clk);
    #1;
    check("reset_hold", {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 8'd0});
    @(negedge video_clk); reset_n = 1'b1;
    model_idle(10'd0, 10'd0, 8'd0);
    fs_save = fs_cnt;
    cyc(1'b1, 1'b1, 1'b1, 10'd321, 10'd2, 12'h5A5, 1'b1, "post_rst");
    check_val("no_partial_line", int'({red, green, blue}), 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 10'(322 + i), 10'd2, 12'h5A5, 1'b1, "post_rst");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'h000, 1'b1, "flush");
    check_val("no_spurious_fs", fs_cnt - fs_save, 0);

    // Frame sweep: first frame, underrun frame, border/white frame, then wrap
    fs_cnt = 0; nz_cnt = 0;
    frame(-1, -1, 12'hF0A);
    check_val("active_pixels", nz_cnt, 24);
    check_val("first_fs", fs_cnt, 1);
    check_val("fc_after_1", int'(frame_count), 1);
    frame(2, 1, 12'hF0A);
    check_val("underrun_cleared", int'(underrun), 0);
    frame(-1, -1, 12'hFFF);
    for (int f = 3; f < 256; f++) frame(-1, -1, 12'h0F0);
    check_val("fc_wrap", int'(frame_count), 0);
    check_val("fs_count_256", fs_cnt, 256);
    frame(-1, -1, 12'h0F0);
    check_val("fc_after_wrap", int'(frame_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
